// File: rtl/adc_level_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : adc_level_checker_if
// Description : Wishbone slave bus bundle for the ADC level checker.
// Revision    : 1.0 - initial release
// ============================================================================
interface adc_level_checker_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [15:0] wb_adr_i;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );
endinterface
`default_nettype wire

// File: rtl/adc_level_checker.sv
`default_nettype none
// ============================================================================
// Module      : adc_level_checker
// Description : Per-channel ADC soft/hard limit monitor with Wishbone access
//               to the threshold RAM and the check-enable registers.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_level_checker (
    input  logic                      clk,
    input  logic                      reset,
    adc_level_checker_if.slave        wb,
    input  logic                      adc_strb,
    input  logic [4:0]                adc_channel,
    input  logic [11:0]               adc_result,
    input  logic                      soft_reset,
    input  logic                      hard_en,
    input  logic                      soft_en,
    output logic                      soft_viol,
    output logic                      hard_viol,
    output logic [31:0]               v_in_range,
    output logic [6:0]                ram_raddr,
    input  logic [11:0]               ram_rdata,
    output logic [6:0]                ram_waddr,
    output logic [11:0]               ram_wdata,
    output logic                      ram_wen
);

    localparam logic [2:0]  WB_IDLE = 3'd0, WB_WR = 3'd1, WB_RD = 3'd2,
                            WB_RDD  = 3'd3, WB_ACK = 3'd4;
    localparam logic [2:0]  CK_IDLE  = 3'd0, CK_RD_SL = 3'd1, CK_RD_SH = 3'd2,
                            CK_RD_HL = 3'd3, CK_RD_HH = 3'd4, CK_CMP   = 3'd5;
    localparam logic [15:0] ADR_SOFT_EN = 16'h0080;
    localparam logic [15:0] ADR_HARD_EN = 16'h0081;

    logic [2:0]  wb_state_q, wb_state_d;
    logic [15:0] req_adr_q, req_adr_d;
    logic [11:0] req_dat_q, req_dat_d;
    logic        wb_ack_q, wb_ack_d;
    logic [15:0] wb_dat_q, wb_dat_d;
    logic        ram_wen_q, ram_wen_d;
    logic        soft_reg_q, soft_reg_d;
    logic        hard_reg_q, hard_reg_d;

    logic [2:0]  ck_state_q, ck_state_d;
    logic [4:0]  cur_ch_q, cur_ch_d;
    logic [11:0] cur_val_q, cur_val_d;
    logic        pend_q, pend_d;
    logic [4:0]  pend_ch_q, pend_ch_d;
    logic [11:0] pend_val_q, pend_val_d;
    logic        sv_q, sv_d;
    logic        hv_q, hv_d;
    logic        soft_viol_q, soft_viol_d;
    logic        hard_viol_q, hard_viol_d;
    logic [31:0] v_in_range_q, v_in_range_d;

    logic        req_is_ram;
    logic        wb_grant;
    logic        ck_start;
    logic        soft_hit;
    logic        hard_hit;
    logic        unused_dat_hi;

    assign req_is_ram    = (req_adr_q[15:7] == 9'd0);
    // A waiting WB read takes the RAM port only while the checker is idle.
    assign wb_grant      = (wb_state_q == WB_RD) && req_is_ram && (ck_state_q == CK_IDLE);
    assign ck_start      = (ck_state_q == CK_IDLE) && !wb_grant && (pend_q || adc_strb) && !soft_reset;
    assign soft_hit      = sv_q && soft_en && soft_reg_q;
    assign hard_hit      = (hv_q || (cur_val_q > ram_rdata)) && hard_en && hard_reg_q;
    assign unused_dat_hi = ^wb.wb_dat_i[15:12];

    always_comb begin
        wb_state_d = wb_state_q;
        req_adr_d  = req_adr_q;
        req_dat_d  = req_dat_q;
        wb_ack_d   = 1'b0;
        wb_dat_d   = wb_dat_q;
        ram_wen_d  = 1'b0;
        soft_reg_d = soft_reg_q;
        hard_reg_d = hard_reg_q;
        case (wb_state_q)
            WB_IDLE: begin
                if (wb.wb_cyc_i && wb.wb_stb_i) begin
                    req_adr_d  = wb.wb_adr_i;
                    req_dat_d  = wb.wb_dat_i[11:0];
                    ram_wen_d  = wb.wb_we_i && (wb.wb_adr_i[15:7] == 9'd0);
                    wb_state_d = wb.wb_we_i ? WB_WR : WB_RD;
                end
            end
            WB_WR: begin
                if (req_adr_q == ADR_SOFT_EN) soft_reg_d = req_dat_q[0];
                if (req_adr_q == ADR_HARD_EN) hard_reg_d = req_dat_q[0];
                wb_ack_d   = 1'b1;
                wb_state_d = WB_ACK;
            end
            WB_RD: begin
                if (req_is_ram) begin
                    if (wb_grant) wb_state_d = WB_RDD;
                end else begin
                    if (req_adr_q == ADR_SOFT_EN)      wb_dat_d = {15'd0, soft_reg_q};
                    else if (req_adr_q == ADR_HARD_EN) wb_dat_d = {15'd0, hard_reg_q};
                    else                               wb_dat_d = 16'd0;
                    wb_ack_d   = 1'b1;
                    wb_state_d = WB_ACK;
                end
            end
            WB_RDD: begin
                wb_dat_d   = {4'd0, ram_rdata};
                wb_ack_d   = 1'b1;
                wb_state_d = WB_ACK;
            end
            WB_ACK:  wb_state_d = WB_IDLE;
            default: wb_state_d = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) ck_state_q <= CK_IDLE;
        else       ck_state_q <= ck_state_d;
    end

    always_comb begin
        ck_state_d = ck_state_q;
        case (ck_state_q)
            CK_IDLE:  if (ck_start) ck_state_d = CK_RD_SL;
            CK_RD_SL: ck_state_d = CK_RD_SH;
            CK_RD_SH: ck_state_d = CK_RD_HL;
            CK_RD_HL: ck_state_d = CK_RD_HH;
            CK_RD_HH: ck_state_d = CK_CMP;
            CK_CMP:   ck_state_d = CK_IDLE;
            default:  ck_state_d = CK_IDLE;
        endcase
        if (soft_reset) ck_state_d = CK_IDLE;
    end

    always_comb begin
        ram_raddr = 7'd0;
        case (ck_state_q)
            CK_IDLE:  if (wb_grant) ram_raddr = req_adr_q[6:0];
            CK_RD_SL: ram_raddr = {1'b0, cur_ch_q, 1'b0};
            CK_RD_SH: ram_raddr = {1'b0, cur_ch_q, 1'b1};
            CK_RD_HL: ram_raddr = {1'b1, cur_ch_q, 1'b0};
            CK_RD_HH: ram_raddr = {1'b1, cur_ch_q, 1'b1};
            default:  ram_raddr = 7'd0;
        endcase
    end

    // Each limit arrives one state after its address; the last is checked in CMP.
    always_comb begin
        cur_ch_d     = cur_ch_q;
        cur_val_d    = cur_val_q;
        pend_d       = pend_q;
        pend_ch_d    = pend_ch_q;
        pend_val_d   = pend_val_q;
        sv_d         = sv_q;
        hv_d         = hv_q;
        soft_viol_d  = 1'b0;
        hard_viol_d  = 1'b0;
        v_in_range_d = v_in_range_q;
        if (ck_start) begin
            sv_d = 1'b0;
            hv_d = 1'b0;
            if (pend_q) begin
                cur_ch_d  = pend_ch_q;
                cur_val_d = pend_val_q;
                pend_d    = adc_strb;
                if (adc_strb) begin
                    pend_ch_d  = adc_channel;
                    pend_val_d = adc_result;
                end
            end else begin
                cur_ch_d  = adc_channel;
                cur_val_d = adc_result;
            end
        end else if (adc_strb) begin
            // A newer sample replaces one already waiting in the slot.
            pend_d     = 1'b1;
            pend_ch_d  = adc_channel;
            pend_val_d = adc_result;
        end
        case (ck_state_q)
            CK_RD_SH: sv_d = (cur_val_q < ram_rdata);
            CK_RD_HL: sv_d = sv_q || (cur_val_q > ram_rdata);
            CK_RD_HH: hv_d = (cur_val_q < ram_rdata);
            CK_CMP: begin
                soft_viol_d            = soft_hit;
                hard_viol_d            = hard_hit;
                v_in_range_d[cur_ch_q] = !(soft_hit || hard_hit);
            end
            default: ;
        endcase
        if (soft_reset) begin
            pend_d       = 1'b0;
            soft_viol_d  = 1'b0;
            hard_viol_d  = 1'b0;
            v_in_range_d = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_state_q   <= WB_IDLE;
            req_adr_q    <= 16'd0;
            req_dat_q    <= 12'd0;
            wb_ack_q     <= 1'b0;
            wb_dat_q     <= 16'd0;
            ram_wen_q    <= 1'b0;
            soft_reg_q   <= 1'b0;
            hard_reg_q   <= 1'b0;
            cur_ch_q     <= 5'd0;
            cur_val_q    <= 12'd0;
            pend_q       <= 1'b0;
            pend_ch_q    <= 5'd0;
            pend_val_q   <= 12'd0;
            sv_q         <= 1'b0;
            hv_q         <= 1'b0;
            soft_viol_q  <= 1'b0;
            hard_viol_q  <= 1'b0;
            v_in_range_q <= 32'd0;
        end else begin
            wb_state_q   <= wb_state_d;
            req_adr_q    <= req_adr_d;
            req_dat_q    <= req_dat_d;
            wb_ack_q     <= wb_ack_d;
            wb_dat_q     <= wb_dat_d;
            ram_wen_q    <= ram_wen_d;
            soft_reg_q   <= soft_reg_d;
            hard_reg_q   <= hard_reg_d;
            cur_ch_q     <= cur_ch_d;
            cur_val_q    <= cur_val_d;
            pend_q       <= pend_d;
            pend_ch_q    <= pend_ch_d;
            pend_val_q   <= pend_val_d;
            sv_q         <= sv_d;
            hv_q         <= hv_d;
            soft_viol_q  <= soft_viol_d;
            hard_viol_q  <= hard_viol_d;
            v_in_range_q <= v_in_range_d;
        end
    end

    assign wb.wb_ack_o = wb_ack_q;
    assign wb.wb_dat_o = wb_dat_q;
    assign ram_wen     = ram_wen_q;
    assign ram_waddr   = req_adr_q[6:0];
    assign ram_wdata   = req_dat_q;
    assign soft_viol   = soft_viol_q;
    assign hard_viol   = hard_viol_q;
    assign v_in_range  = v_in_range_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_level_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_level_checker
// Description : Directed self-checking bench for adc_level_checker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_level_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        adc_strb;
    logic [4:0]  adc_channel;
    logic [11:0] adc_result;
    logic        soft_reset;
    logic        hard_en;
    logic        soft_en;
    logic        soft_viol;
    logic        hard_viol;
    logic [31:0] v_in_range;
    logic [6:0]  ram_raddr;
    logic [11:0] ram_rdata;
    logic [6:0]  ram_waddr;
    logic [11:0] ram_wdata;
    logic        ram_wen;

    adc_level_checker_if wb_bus ();

    adc_level_checker dut (
        .clk         (clk),
        .reset       (reset),
        .wb          (wb_bus),
        .adc_strb    (adc_strb),
        .adc_channel (adc_channel),
        .adc_result  (adc_result),
        .soft_reset  (soft_reset),
        .hard_en     (hard_en),
        .soft_en     (soft_en),
        .soft_viol   (soft_viol),
        .hard_viol   (hard_viol),
        .v_in_range  (v_in_range),
        .ram_raddr   (ram_raddr),
        .ram_rdata   (ram_rdata),
        .ram_waddr   (ram_waddr),
        .ram_wdata   (ram_wdata),
        .ram_wen     (ram_wen)
    );

    always #5 clk = ~clk;

    logic [11:0] mem [0:127];
    always @(posedge clk) begin
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
        ram_rdata <= mem[ram_raddr];
    end

    int vectors = 0;
    int miscompares = 0;
    int ack_cnt = 0;
    int wen_cnt = 0;
    int soft_cnt = 0;
    int hard_cnt = 0;

    always @(posedge clk) begin
        if (wb_bus.wb_ack_o) ack_cnt  <= ack_cnt + 1;
        if (ram_wen)         wen_cnt  <= wen_cnt + 1;
        if (soft_viol)       soft_cnt <= soft_cnt + 1;
        if (hard_viol)       hard_cnt <= hard_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [15:0] adr, input logic [15:0] dat,
                           output logic [15:0] rd);
        bit got = 0;
        rd = 16'hDEAD;
        @(negedge clk);
        wb_bus.wb_cyc_i = 1'b1;
        wb_bus.wb_stb_i = 1'b1;
        wb_bus.wb_we_i  = we;
        wb_bus.wb_adr_i = adr;
        wb_bus.wb_dat_i = dat;
        @(negedge clk);
        wb_bus.wb_cyc_i = 1'b0;
        wb_bus.wb_stb_i = 1'b0;
        wb_bus.wb_we_i  = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            if (wb_bus.wb_ack_o) begin
                got = 1;
                rd  = wb_bus.wb_dat_o;
            end else begin
                @(negedge clk);
            end
        end
        if (!got) check($sformatf("ack_timeout_%0h", adr), 32'd0, 32'd1);
    endtask

    task automatic sample(input logic [4:0] ch, input logic [11:0] v,
                          input bit es, input bit eh, input string tag);
        int ns = 0;
        int nh = 0;
        @(negedge clk);
        adc_strb    = 1'b1;
        adc_channel = ch;
        adc_result  = v;
        @(negedge clk);
        adc_strb = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (soft_viol) ns++;
            if (hard_viol) nh++;
            @(negedge clk);
        end
        check({tag, "_soft"}, ns, {31'd0, es});
        check({tag, "_hard"}, nh, {31'd0, eh});
        check({tag, "_inrange"}, {31'd0, v_in_range[ch]}, {31'd0, !(es || eh)});
    endtask

    logic [15:0] rd;
    int s0, h0, w0;

    initial begin
        reset = 1'b1;
        adc_strb = 1'b0; adc_channel = 5'd0; adc_result = 12'd0;
        soft_reset = 1'b0; hard_en = 1'b1; soft_en = 1'b1;
        wb_bus.wb_cyc_i = 1'b0; wb_bus.wb_stb_i = 1'b0; wb_bus.wb_we_i = 1'b0;
        wb_bus.wb_adr_i = 16'd0; wb_bus.wb_dat_i = 16'd0;
        repeat (3) @(negedge clk);
        check("rst_ack", {31'd0, wb_bus.wb_ack_o}, 32'd0);
        check("rst_dat", {16'd0, wb_bus.wb_dat_o}, 32'd0);
        check("rst_viol", {30'd0, soft_viol, hard_viol}, 32'd0);
        check("rst_wen", {31'd0, ram_wen}, 32'd0);
        check("rst_inrange", v_in_range, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int c = 0; c < 32; c++) begin
            logic [4:0] ch;
            ch = c[4:0];
            wb_xfer(1'b1, {9'd0, 1'b0, ch, 1'b0}, 16'h0001, rd);
            wb_xfer(1'b1, {9'd0, 1'b0, ch, 1'b1}, 16'h01FF, rd);
            wb_xfer(1'b1, {9'd0, 1'b1, ch, 1'b0}, 16'h000F, rd);
            wb_xfer(1'b1, {9'd0, 1'b1, ch, 1'b1}, 16'h00FF, rd);
        end
        sample(5'd3, 12'h000, 1'b0, 1'b0, "pre_enable");
        wb_xfer(1'b1, 16'h0080, 16'h0001, rd);
        wb_xfer(1'b1, 16'h0081, 16'h0001, rd);
        @(negedge clk);
        check("ack_count", ack_cnt, 32'd130);
        check("wen_count", wen_cnt, 32'd128);

        for (int c = 0; c < 32; c++) sample(c[4:0], 12'h050, 1'b0, 1'b0, "nominal");
        check("all_in_range", v_in_range, 32'hFFFF_FFFF);
        for (int c = 0; c < 32; c++) begin
            sample(c[4:0], 12'h00E, 1'b0, 1'b1, "below_hard");
            sample(c[4:0], 12'h100, 1'b0, 1'b1, "above_hard");
            sample(c[4:0], 12'h000, 1'b1, 1'b1, "below_soft");
            sample(c[4:0], 12'h200, 1'b1, 1'b1, "above_soft");
        end
        check("none_in_range", v_in_range, 32'd0);

        sample(5'd10, 12'h00F, 1'b0, 1'b0, "edge_hard_lo");
        sample(5'd10, 12'h0FF, 1'b0, 1'b0, "edge_hard_hi");
        sample(5'd10, 12'h001, 1'b0, 1'b1, "edge_soft_lo");
        sample(5'd10, 12'h1FF, 1'b0, 1'b1, "edge_soft_hi");

        wb_xfer(1'b0, 16'h0000, 16'd0, rd); check("rd_soft_lo", {16'd0, rd}, 32'h001);
        wb_xfer(1'b0, 16'h0001, 16'd0, rd); check("rd_soft_hi", {16'd0, rd}, 32'h1FF);
        wb_xfer(1'b0, 16'h0040, 16'd0, rd); check("rd_hard_lo", {16'd0, rd}, 32'h00F);
        wb_xfer(1'b0, 16'h0041, 16'd0, rd); check("rd_hard_hi", {16'd0, rd}, 32'h0FF);
        wb_xfer(1'b0, 16'h007E, 16'd0, rd); check("rd_ch31_hl", {16'd0, rd}, 32'h00F);
        wb_xfer(1'b0, 16'h0080, 16'd0, rd); check("rd_soft_en", {16'd0, rd}, 32'h1);
        wb_xfer(1'b0, 16'h0081, 16'd0, rd); check("rd_hard_en", {16'd0, rd}, 32'h1);
        wb_xfer(1'b0, 16'h0123, 16'd0, rd); check("rd_unmapped", {16'd0, rd}, 32'h0);

        w0 = wen_cnt;
        wb_xfer(1'b1, 16'h0180, 16'h0555, rd);
        wb_xfer(1'b1, 16'h0200, 16'h0555, rd);
        @(negedge clk);
        check("unmapped_no_wen", wen_cnt - w0, 32'd0);
        wb_xfer(1'b0, 16'h0000, 16'd0, rd); check("rd_after_unmapped", {16'd0, rd}, 32'h001);

        hard_en = 1'b0;
        sample(5'd3, 12'h00E, 1'b0, 1'b0, "hard_off_lo");
        sample(5'd3, 12'h000, 1'b1, 1'b0, "hard_off_soft");
        hard_en = 1'b1;
        soft_en = 1'b0;
        sample(5'd3, 12'h200, 1'b0, 1'b1, "soft_off");
        soft_en = 1'b1;

        // back-to-back strobes: second waits in the pending slot
        s0 = soft_cnt; h0 = hard_cnt;
        @(negedge clk); adc_strb = 1'b1; adc_channel = 5'd5; adc_result = 12'h050;
        @(negedge clk); adc_channel = 5'd6; adc_result = 12'h000;
        @(negedge clk); adc_strb = 1'b0;
        repeat (20) @(negedge clk);
        check("pend_soft", soft_cnt - s0, 32'd1);
        check("pend_hard", hard_cnt - h0, 32'd1);
        check("pend_v5", {31'd0, v_in_range[5]}, 32'd1);
        check("pend_v6", {31'd0, v_in_range[6]}, 32'd0);

        // WB read issued while the checker is busy
        s0 = soft_cnt; h0 = hard_cnt;
        @(negedge clk); adc_strb = 1'b1; adc_channel = 5'd9; adc_result = 12'h050;
        wb_xfer(1'b0, 16'h0041, 16'd0, rd);
        adc_strb = 1'b0;
        check("busy_rd", {16'd0, rd}, 32'h0FF);
        repeat (12) @(negedge clk);
        check("busy_v9", {31'd0, v_in_range[9]}, 32'd1);
        check("busy_viol", (soft_cnt - s0) + (hard_cnt - h0), 32'd0);

        @(negedge clk); soft_reset = 1'b1;
        @(negedge clk); soft_reset = 1'b0;
        check("srst_inrange", v_in_range, 32'd0);
        s0 = soft_cnt; h0 = hard_cnt;
        @(negedge clk); adc_strb = 1'b1; adc_channel = 5'd4; adc_result = 12'h000;
        @(negedge clk); adc_channel = 5'd8;
        @(negedge clk); adc_strb = 1'b0; soft_reset = 1'b1;
        @(negedge clk); soft_reset = 1'b0;
        repeat (16) @(negedge clk);
        check("srst_abort_viol", (soft_cnt - s0) + (hard_cnt - h0), 32'd0);
        check("srst_abort_inrange", v_in_range, 32'd0);
        sample(5'd4, 12'h000, 1'b1, 1'b1, "after_srst");

        // reset while a register write is in flight: no ack, register stays cleared
        @(negedge clk);
        wb_bus.wb_cyc_i = 1'b1; wb_bus.wb_stb_i = 1'b1; wb_bus.wb_we_i = 1'b1;
        wb_bus.wb_adr_i = 16'h0080; wb_bus.wb_dat_i = 16'h0001;
        @(negedge clk);
        wb_bus.wb_cyc_i = 1'b0; wb_bus.wb_stb_i = 1'b0; wb_bus.wb_we_i = 1'b0;
        reset = 1'b1;
        @(negedge clk); check("rst_mid_ack0", {31'd0, wb_bus.wb_ack_o}, 32'd0);
        @(negedge clk); check("rst_mid_ack1", {31'd0, wb_bus.wb_ack_o}, 32'd0);
        reset = 1'b0;
        @(negedge clk); check("rst_mid_ack2", {31'd0, wb_bus.wb_ack_o}, 32'd0);
        wb_xfer(1'b0, 16'h0080, 16'd0, rd); check("rst_mid_soft_en", {16'd0, rd}, 32'h0);
        sample(5'd0, 12'h000, 1'b0, 1'b0, "rst_disabled");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
